bus_rr_arbiter: RTL

- Shares one valid/ready slave port (4-bit addr, 4-bit wdata, 4-bit rdata) between NUM_MASTERS requesters using round-robin arbitration.
- Runs each transaction as a three-phase sequence: arbitrate, drive slave, respond. Aborts with an error if the slave does not answer within TIMEOUT cycles.
- Sits between the master instances and a single slave in a bus subsystem.

---
 rtl/bus_rr_arbiter_if.sv | 27 ++
 rtl/bus_rr_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter_if.sv
// Bus bundle between the requesting masters, the round-robin arbiter and the shared slave.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface bus_rr_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  logic [NUM_MASTERS-1:0]   m_valid;
  logic [4*NUM_MASTERS-1:0] m_addr;
  logic [4*NUM_MASTERS-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]   m_ready;
  logic [3:0]               m_rdata;
  logic                     m_err;
  logic                     s_valid;
  logic [3:0]               s_addr;
  logic [3:0]               s_wdata;
  logic [3:0]               s_rdata;
  logic                     s_ready;

  modport master (
    input  m_valid, m_addr, m_wdata, s_rdata, s_ready,
    output m_ready, m_rdata, m_err, s_valid, s_addr, s_wdata
  );

  modport slave (
    output m_valid, m_addr, m_wdata, s_rdata, s_ready,
    input  m_ready, m_rdata, m_err, s_valid, s_addr, s_wdata
  );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready slave among NUM_MASTERS requesters,
// with an IDLE -> BUSY -> RESP transaction sequence and a slave-response timeout.
module bus_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT     = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  bus_rr_arbiter_if.master       bus,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   busy,
  output logic [7:0]             txn_count,
  output logic [3:0]             err_count
);
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IW:0]   NM       = (IW+1)'(NUM_MASTERS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MASTERS - 1);
  localparam logic [7:0]    T_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                 state_reg, state_next;
  logic [IW-1:0]          ptr_reg, ptr_next;
  logic [IW-1:0]          gidx_reg, gidx_next;
  logic [NUM_MASTERS-1:0] grant_reg, grant_next;
  logic [3:0]             addr_reg, addr_next;
  logic [3:0]             wdata_reg, wdata_next;
  logic [7:0]             timer_reg, timer_next;
  logic [3:0]             rdata_reg, rdata_next;
  logic                   err_reg, err_next;
  logic [7:0]             txn_reg, txn_next;
  logic [3:0]             errc_reg, errc_next;

  logic                   pick_found;
  logic [IW-1:0]          pick_idx;
  logic [IW:0]            cand;

  // First requester at or after the pointer, searching upward with wrap-around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = {1'b0, ptr_reg} + (IW+1)'(k);
      if (cand >= NM) cand = cand - NM;
      if (!pick_found && bus.m_valid[cand[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      gidx_reg  <= '0;
      grant_reg <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      timer_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
      txn_reg   <= '0;
      errc_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      gidx_reg  <= gidx_next;
      grant_reg <= grant_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      timer_reg <= timer_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
      txn_reg   <= txn_next;
      errc_reg  <= errc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    gidx_next  = gidx_reg;
    grant_next = grant_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    timer_next = timer_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    txn_next   = txn_reg;
    errc_next  = errc_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next = BUSY;
          gidx_next  = pick_idx;
          grant_next = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick_idx;
          addr_next  = bus.m_addr[4*pick_idx +: 4];
          wdata_next = bus.m_wdata[4*pick_idx +: 4];
          timer_next = '0;
        end
      end
      BUSY: begin
        // A slave answer on the last allowed cycle still counts as a normal completion.
        if (bus.s_ready) begin
          rdata_next = bus.s_rdata;
          err_next   = 1'b0;
          state_next = RESP;
        end else if (timer_reg == T_LAST) begin
          rdata_next = '0;
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end
      RESP: begin
        ptr_next   = (gidx_reg == LAST_IDX) ? '0 : gidx_reg + IW'(1);
        txn_next   = txn_reg + 8'd1;
        if (err_reg && errc_reg != 4'hF) errc_next = errc_reg + 4'd1;
        grant_next = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.s_valid = (state_reg == BUSY);
  assign bus.s_addr  = (state_reg == BUSY) ? addr_reg : '0;
  assign bus.s_wdata = (state_reg == BUSY) ? wdata_reg : '0;
  assign bus.m_ready = (state_reg == RESP) ? grant_reg : '0;
  assign bus.m_rdata = rdata_reg;
  assign bus.m_err   = err_reg;
  assign grant       = grant_reg;
  assign busy        = (state_reg != IDLE);
  assign txn_count   = txn_reg;
  assign err_count   = errc_reg;
endmodule
